// File: rtl/keypad_pkg.sv
// Keypad scanner shared types and key map.
// Holds the scan FSM states and the row/column to hex code lookup.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Both stages reset to all ones (idle, pulled-up level).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce.
// Registers one hex digit per physical press, keeps the last two.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT     = 48000,
  parameter int DEBOUNCE_COUNT = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_recent,
  output logic [3:0] digit_prev,
  output logic       key_valid
);

  localparam int MAXC = (SCAN_COUNT > DEBOUNCE_COUNT) ?
                        SCAN_COUNT : DEBOUNCE_COUNT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_COUNT - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_COUNT - 1);

  logic [3:0] rows_s;

  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    rec_q, rec_d;
  logic [3:0]    prev_q, prev_d;
  logic          kv_q, kv_d;
  logic [1:0]    low_row;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // Lowest-index row currently pulled low
  always_comb begin
    low_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_s[r]) low_row = 2'(r);
    end
  end

  // State, counter and digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      rec_q   <= 4'h0;
      prev_q  <= 4'h0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rec_q   <= rec_d;
      prev_q  <= prev_d;
      kv_q    <= kv_d;
    end
  end

  // Next-state: scan, debounce press, hold, debounce release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    col_d   = col_q;
    row_d   = row_q;
    rec_d   = rec_q;
    prev_d  = prev_q;
    kv_d    = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rows_s != 4'b1111) begin
            row_d   = low_row;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (rows_s[row_q]) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          prev_d  = rec_q;
          rec_d   = key_code(row_q, col_q);
          kv_d    = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (rows_s[row_q]) state_d = RELEASE;
      end
      RELEASE: begin
        if (!rows_s[row_q]) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  assign cols         = ~(4'b0001 << col_q);
  assign digit_recent = rec_q;
  assign digit_prev   = prev_q;
  assign key_valid    = kv_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// A keypad model pulls rows low for pressed keys in driven columns.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_recent;
  logic [3:0] digit_prev;
  logic       key_valid;

  logic [15:0] pressed = '0;
  int compared = 0;
  int mismatched = 0;
  int pulses = 0;

  keypad_scanner #(
    .SCAN_COUNT     (4),
    .DEBOUNCE_COUNT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rows         (rows),
    .cols         (cols),
    .digit_recent (digit_recent),
    .digit_prev   (digit_prev),
    .key_valid    (key_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid) pulses++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    reset = 1'b1;
    tick(3);
    compared++;
    if (cols !== 4'b1110) begin
      mismatched++;
      $display("FAIL reset_cols got %b want 1110", cols);
    end
    compared++;
    if (digit_recent !== 4'h0 || digit_prev !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_digits got %h/%h want 0/0",
               digit_recent, digit_prev);
    end
    compared++;
    if (key_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_kv got %b want 0", key_valid);
    end
    reset = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      exp = ~(4'b0001 << ((i / 4) % 4));
      compared++;
      if (cols !== exp) begin
        mismatched++;
        $display("FAIL scan_cols step %0d got %b want %b", i, cols, exp);
      end
      tick(1);
    end
  endtask

  task automatic test_clean_press;
    int p0;
    p0 = pulses;
    pressed[5] = 1'b1;
    tick(100);
    compared++;
    if (cols !== 4'b1101) begin
      mismatched++;
      $display("FAIL press5_held_cols got %b want 1101", cols);
    end
    pressed[5] = 1'b0;
    tick(10);
    compared++;
    if (cols !== 4'b1101) begin
      mismatched++;
      $display("FAIL press5_release_hold got %b want 1101", cols);
    end
    tick(1);
    compared++;
    if (cols !== 4'b1011) begin
      mismatched++;
      $display("FAIL press5_rescan got %b want 1011", cols);
    end
    compared++;
    if (pulses - p0 !== 1) begin
      mismatched++;
      $display("FAIL press5_pulses got %0d want 1", pulses - p0);
    end
    compared++;
    if (digit_recent !== 4'h5 || digit_prev !== 4'h0) begin
      mismatched++;
      $display("FAIL press5_digits got %h/%h want 5/0",
               digit_recent, digit_prev);
    end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed[8] = ~pressed[8];
      tick(3);
    end
    pressed[8] = 1'b0;
    tick(40);
    compared++;
    if (pulses !== p0) begin
      mismatched++;
      $display("FAIL bounce_pulses got %0d want 0", pulses - p0);
    end
    compared++;
    if (digit_recent !== 4'h5 || digit_prev !== 4'h0) begin
      mismatched++;
      $display("FAIL bounce_digits got %h/%h want 5/0",
               digit_recent, digit_prev);
    end
  endtask

  task automatic test_sequence;
    int p0;
    p0 = pulses;
    pressed[3] = 1'b1;
    tick(60);
    pressed[3] = 1'b0;
    tick(40);
    compared++;
    if (digit_recent !== 4'hA || digit_prev !== 4'h5) begin
      mismatched++;
      $display("FAIL seq_a_digits got %h/%h want A/5",
               digit_recent, digit_prev);
    end
    pressed[13] = 1'b1;
    tick(60);
    pressed[13] = 1'b0;
    tick(40);
    compared++;
    if (digit_recent !== 4'h0 || digit_prev !== 4'hA) begin
      mismatched++;
      $display("FAIL seq_0_digits got %h/%h want 0/A",
               digit_recent, digit_prev);
    end
    compared++;
    if (pulses - p0 !== 2) begin
      mismatched++;
      $display("FAIL seq_pulses got %0d want 2", pulses - p0);
    end
  endtask

  task automatic test_multi_key;
    int p0;
    p0 = pulses;
    pressed[0] = 1'b1;
    tick(60);
    pressed[4] = 1'b1;
    pressed[1] = 1'b1;
    tick(60);
    compared++;
    if (digit_recent !== 4'h1 || digit_prev !== 4'h0) begin
      mismatched++;
      $display("FAIL multi_1_digits got %h/%h want 1/0",
               digit_recent, digit_prev);
    end
    compared++;
    if (pulses - p0 !== 1) begin
      mismatched++;
      $display("FAIL multi_1_pulses got %0d want 1", pulses - p0);
    end
    pressed[0] = 1'b0;
    pressed[4] = 1'b0;
    tick(60);
    compared++;
    if (digit_recent !== 4'h2 || digit_prev !== 4'h1) begin
      mismatched++;
      $display("FAIL multi_2_digits got %h/%h want 2/1",
               digit_recent, digit_prev);
    end
    compared++;
    if (pulses - p0 !== 2) begin
      mismatched++;
      $display("FAIL multi_2_pulses got %0d want 2", pulses - p0);
    end
    pressed[1] = 1'b0;
    tick(40);
  endtask

  task automatic test_reset_mid;
    int p0;
    int n;
    p0 = pulses;
    n = 0;
    while (cols !== 4'b1110 && n < 100) begin
      tick(1);
      n++;
    end
    compared++;
    if (cols !== 4'b1110) begin
      mismatched++;
      $display("FAIL mid_wait_col0 got %b want 1110", cols);
    end
    pressed[14] = 1'b1;
    n = 0;
    while (cols !== 4'b1011 && n < 100) begin
      tick(1);
      n++;
    end
    compared++;
    if (cols !== 4'b1011) begin
      mismatched++;
      $display("FAIL mid_wait_col2 got %b want 1011", cols);
    end
    tick(6);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    pressed[14] = 1'b0;
    compared++;
    if (digit_recent !== 4'h0 || digit_prev !== 4'h0) begin
      mismatched++;
      $display("FAIL mid_digits got %h/%h want 0/0",
               digit_recent, digit_prev);
    end
    compared++;
    if (cols !== 4'b1110) begin
      mismatched++;
      $display("FAIL mid_cols got %b want 1110", cols);
    end
    tick(4);
    compared++;
    if (cols !== 4'b1101) begin
      mismatched++;
      $display("FAIL mid_rescan got %b want 1101", cols);
    end
    tick(20);
    compared++;
    if (pulses !== p0) begin
      mismatched++;
      $display("FAIL mid_pulses got %0d want 0", pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_sequence();
    test_multi_key();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
